detector_sequencer: RTL and testbench

- Controller that time-shares one pair-of-ones serial detector (`top`-style FSM: idle, s0, s1) between N_REQ requesters.
- Arbitrates word requests round-robin, resets and primes the detector, then shifts the word MSB-first into the detector's din.
- Counts the detector's dout pulses and returns the count, plus a self-check flag, on a valid/ready response channel.
- Sits between the requester ports and the detector instance; the detector's reset and din are owned by this block.

---
 rtl/detector_sequencer_pkg.sv | 20 ++
 rtl/detector_sequencer_arbiter.sv | 33 +++
 rtl/detector_sequencer.sv | 124 ++++++++++++
 tb/tb_detector_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detector_sequencer_pkg.sv
// rtl/detector_sequencer_pkg.sv - shared state encoding and index helper for the detector sequencer
package detector_sequencer_pkg;

  typedef enum logic [4:0] {
    ST_ARB   = 5'b00001,
    ST_RST   = 5'b00010,
    ST_PRIME = 5'b00100,
    ST_SHIFT = 5'b01000,
    ST_DONE  = 5'b10000
  } seq_state_t;

  // (a + b) mod n for a, b already in [0, n)
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/detector_sequencer_arbiter.sv
// rtl/detector_sequencer_arbiter.sv - round-robin arbiter, first request at or above the pointer wins
module rr_arbiter
  import detector_sequencer_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_valid
);

  logic [ID_W-1:0] w_cand;

  // Scan from farthest to nearest so the nearest requester is the last writer.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = ID_W'(wrap_add(int'(i_ptr), k, N_REQ));
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

  assign o_grant = o_valid ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/detector_sequencer.sv
// rtl/detector_sequencer.sv - time-shares one pair-of-ones detector between requesters
module detector_sequencer
  import detector_sequencer_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W + 1),
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               det_rst,
  output logic               det_din,
  input  logic               det_dout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [CNT_W-1:0]   rsp_count,
  output logic               rsp_mismatch,
  output logic               busy
);

  seq_state_t       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [W-1:0]     r_word;
  logic [W-1:0]     r_shift;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_count;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_gidx;
  logic             w_gvalid;
  logic [W-1:0]     w_sel_word;
  logic [CNT_W-1:0] w_pop;
  logic [CNT_W-1:0] w_expected;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  always_comb begin
    w_sel_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i == int'(w_gidx)) w_sel_word = req_data[i*W +: W];
    end
  end

  // Reference count comes from the latched word, not the live request bus.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++) begin
      w_pop = w_pop + CNT_W'(r_word[i]);
    end
    w_expected = w_pop >> 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ARB;
      r_ptr   <= '0;
      r_id    <= '0;
      r_word  <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_gvalid) begin
            r_word  <= w_sel_word;
            r_shift <= w_sel_word;
            r_id    <= w_gidx;
            r_ptr   <= ID_W'(wrap_add(int'(w_gidx), 1, N_REQ));
            r_state <= ST_RST;
          end
        end
        ST_RST: begin
          r_count <= '0;
          r_idx   <= '0;
          r_state <= ST_PRIME;
        end
        ST_PRIME: begin
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_count <= r_count + CNT_W'(det_dout);
          r_shift <= {r_shift[W-2:0], 1'b0};
          if (r_idx == CNT_W'(W - 1)) begin
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) r_state <= ST_ARB;
        end
        default: begin
          r_state <= ST_ARB;
        end
      endcase
    end
  end

  assign req_ready    = (!rst && r_state == ST_ARB) ? w_grant : '0;
  assign det_rst      = rst | (r_state == ST_RST);
  assign det_din      = !rst && (r_state == ST_SHIFT) && r_shift[W-1];
  assign rsp_valid    = !rst && (r_state == ST_DONE);
  assign rsp_id       = rsp_valid ? r_id : '0;
  assign rsp_count    = rsp_valid ? r_count : '0;
  assign rsp_mismatch = rsp_valid && (w_expected != r_count);
  assign busy         = !rst && (r_state != ST_ARB);

endmodule

// File: tb/tb_detector_sequencer.sv
// tb/tb_detector_sequencer.sv - directed-vector bench for detector_sequencer with a pair-of-ones detector model
module tb_detector_sequencer;

  localparam int N_REQ = 2;
  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int ID_W  = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               det_rst;
  logic               det_din;
  logic               det_dout;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [CNT_W-1:0]   rsp_count;
  logic               rsp_mismatch;
  logic               busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  detector_sequencer #(
    .N_REQ (N_REQ),
    .W     (W),
    .CNT_W (CNT_W),
    .ID_W  (ID_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .det_rst      (det_rst),
    .det_din      (det_din),
    .det_dout     (det_dout),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_count    (rsp_count),
    .rsp_mismatch (rsp_mismatch),
    .busy         (busy)
  );

  // Detector: idle for one cycle after reset, then s1 means an odd number of ones seen
  typedef enum logic [1:0] {M_IDLE, M_S0, M_S1} m_state_t;
  m_state_t m_state;
  logic     m_dout;
  logic     sup_req;
  int       sup_seen;

  assign m_dout   = (m_state == M_S1) && det_din;
  assign det_dout = m_dout && !(sup_req && sup_seen == 0);

  always @(posedge clk) begin
    if (det_rst) begin
      m_state <= M_IDLE;
    end else begin
      case (m_state)
        M_IDLE:  m_state <= M_S0;
        M_S0:    if (det_din) m_state <= M_S1;
        M_S1:    if (det_din) m_state <= M_S0;
        default: m_state <= M_IDLE;
      endcase
    end
    if (!sup_req) sup_seen <= 0;
    else if (m_dout) sup_seen <= sup_seen + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a word on requester r and returns one cycle after the accept edge
  task automatic accept_word(input int r, input logic [7:0] w, output int waited);
    req_data[r*W +: W] = w;
    req_valid[r] = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[r] && waited < 40) begin
      tick();
      waited++;
    end
    if (!req_ready[r]) waited = -1;
    tick();
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++; if (det_rst !== 1'b1) begin n_err++; $display("FAIL reset_det_rst: got %b want 1", det_rst); end
    n_vec++; if ({req_ready, det_din, rsp_valid, rsp_id, rsp_count, rsp_mismatch, busy} !== '0) begin
      n_err++; $display("FAIL reset_outputs_zero: got %b want 0", {req_ready, det_din, rsp_valid, rsp_id, rsp_count, rsp_mismatch, busy});
    end
    rst = 1'b0;
    #1;
    n_vec++; if (det_rst !== 1'b0) begin n_err++; $display("FAIL post_reset_det_rst: got %b want 0", det_rst); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int waited, lat;
    rsp_ready = 1'b1;
    accept_word(0, 8'hFF, waited);
    n_vec++; if (waited !== 0) begin n_err++; $display("FAIL single_accept_wait: got %0d want 0", waited); end
    n_vec++; if (det_rst !== 1'b1) begin n_err++; $display("FAIL single_det_rst_pulse: got %b want 1", det_rst); end
    tick();
    n_vec++; if (det_rst !== 1'b0) begin n_err++; $display("FAIL single_det_rst_end: got %b want 0", det_rst); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_rsp(1, lat);
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL single_latency: got %0d want 10", lat); end
    n_vec++; if (rsp_count !== 4'd4) begin n_err++; $display("FAIL single_count: got %0d want 4", rsp_count); end
    n_vec++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    n_vec++; if (rsp_mismatch !== 1'b0) begin n_err++; $display("FAIL single_mismatch: got %b want 0", rsp_mismatch); end
    tick();
    n_vec++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_return_arb: got busy=%b rsp_valid=%b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_words();
    logic [7:0] words [4];
    int         exp_cnt [4];
    int         waited, lat;
    words   = '{8'hA0, 8'h01, 8'h07, 8'h00};
    exp_cnt = '{1, 0, 1, 0};
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      accept_word(1, words[i], waited);
      wait_rsp(0, lat);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL words_latency[%0d]: got %0d want 10", i, lat); end
      n_vec++; if (rsp_count !== CNT_W'(exp_cnt[i])) begin
        n_err++; $display("FAIL words_count[%h]: got %0d want %0d", words[i], rsp_count, exp_cnt[i]);
      end
      n_vec++; if (rsp_id !== 1'b1) begin n_err++; $display("FAIL words_id[%h]: got %0d want 1", words[i], rsp_id); end
      n_vec++; if (rsp_mismatch !== 1'b0) begin n_err++; $display("FAIL words_mismatch[%h]: got %b want 0", words[i], rsp_mismatch); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int g_who [4];
    int g_at  [4];
    int r_idv [4];
    int r_cnv [4];
    int g_cnt, r_cnt, cyc;
    for (int i = 0; i < 4; i++) begin
      g_who[i] = -1; g_at[i] = -100; r_idv[i] = -1; r_cnv[i] = -1;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_data  = {8'h0F, 8'hF0};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    g_cnt = 0; r_cnt = 0; cyc = 0;
    while (r_cnt < 4 && cyc < 100) begin
      if (req_ready != 2'b00 && g_cnt < 4) begin
        g_who[g_cnt] = req_ready[1] ? 1 : 0;
        g_at[g_cnt]  = cyc;
        g_cnt++;
      end
      if (rsp_valid) begin
        r_idv[r_cnt] = int'(rsp_id);
        r_cnv[r_cnt] = int'(rsp_count);
        r_cnt++;
      end
      if (r_cnt < 4) begin
        tick();
        cyc++;
      end
    end
    req_valid = 2'b00;
    n_vec++; if (r_cnt !== 4) begin n_err++; $display("FAIL b2b_responses: got %0d want 4", r_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (g_who[i] !== (i % 2)) begin n_err++; $display("FAIL b2b_grant[%0d]: got %0d want %0d", i, g_who[i], i % 2); end
      n_vec++; if (r_idv[i] !== (i % 2)) begin n_err++; $display("FAIL b2b_rsp_id[%0d]: got %0d want %0d", i, r_idv[i], i % 2); end
      n_vec++; if (r_cnv[i] !== 2) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want 2", i, r_cnv[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      n_vec++; if (g_at[i] - g_at[i-1] !== 12) begin
        n_err++; $display("FAIL b2b_period[%0d]: got %0d want 12", i, g_at[i] - g_at[i-1]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int       waited, lat;
    rsp_ready = 1'b0;
    accept_word(0, 8'h3C, waited);
    req_data[W +: W] = 8'h81;
    req_valid[1] = 1'b1;
    wait_rsp(0, lat);
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL bp_latency: got %0d want 10", lat); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, rsp_valid); end
      n_vec++; if (rsp_count !== 4'd2) begin n_err++; $display("FAIL bp_count_hold[%0d]: got %0d want 2", i, rsp_count); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy[%0d]: got %b want 1", i, busy); end
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_no_ready[%0d]: got %b want 00", i, req_ready); end
    end
    rsp_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_ready_before_hs: got %b want 00", req_ready); end
    tick();
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_next_grant: got %b want 10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(0, lat);
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL bp_second_latency: got %0d want 10", lat); end
    n_vec++; if (rsp_id !== 1'b1 || rsp_count !== 4'd1) begin
      n_err++; $display("FAIL bp_second_rsp: got id=%0d count=%0d want id=1 count=1", rsp_id, rsp_count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int waited, seen;
    rsp_ready = 1'b1;
    accept_word(0, 8'hFF, waited);
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (det_din !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL mid_shift_idx3: got din=%b busy=%b want 1 1", det_din, busy);
    end
    rst = 1'b1;
    #1;
    n_vec++; if ({det_rst, det_din, busy, rsp_valid} !== 4'b1000) begin
      n_err++; $display("FAIL mid_rst_outputs: got %b want 1000", {det_rst, det_din, busy, rsp_valid});
    end
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if ({busy, rsp_valid, det_rst} !== 3'b000) begin
      n_err++; $display("FAIL mid_after_rst: got %b want 000", {busy, rsp_valid, det_rst});
    end
    req_data  = {8'h33, 8'h55};
    req_valid = 2'b11;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_ptr_reset_grant: got %b want 01", req_ready); end
    req_valid = 2'b00;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL mid_no_response: got %0d want 0", seen); end
  endtask

  task automatic test_suppress();
    int waited, lat;
    rsp_ready = 1'b1;
    sup_req = 1'b1;
    accept_word(0, 8'hFF, waited);
    wait_rsp(0, lat);
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL sup_latency: got %0d want 10", lat); end
    n_vec++; if (rsp_count !== 4'd3) begin n_err++; $display("FAIL sup_count: got %0d want 3", rsp_count); end
    n_vec++; if (rsp_mismatch !== 1'b1) begin n_err++; $display("FAIL sup_mismatch: got %b want 1", rsp_mismatch); end
    tick();
    sup_req = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    sup_req   = 1'b0;
    test_reset();
    test_single();
    test_words();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_suppress();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
